// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: shares the register-file write port between WB and the MDU.
// Define REGWR_ARB_STARVE_GUARD_EN to enable the MDU starvation guard (forced WB stall).
module regfile_wr_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock_i,
    input  logic              reset_n_i,
    input  logic              wb_we_i,
    input  logic [4:0]        wb_rd_i,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              mdu_valid_i,
    input  logic [4:0]        mdu_rd_i,
    input  logic [DATA_W-1:0] mdu_data_i,
    output logic              mdu_ready_o,
    output logic              stall_wb_o,
    output logic [31:0]       rf_wen_o,
    output logic [4:0]        rf_waddr_o,
    output logic [DATA_W-1:0] rf_wdata_o
);
    logic              wb_act, mdu_hs, win;
    logic [4:0]        win_rd;
    logic [DATA_W-1:0] win_data;
    logic [31:0]       rf_wen_d, rf_wen_q;
    logic [4:0]        rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;

    assign wb_act      = wb_we_i & (wb_rd_i != 5'd0) & ~stall_wb_o;
    assign mdu_ready_o = ~wb_act;
    assign mdu_hs      = mdu_valid_i & mdu_ready_o;
    assign win         = wb_act | mdu_hs;

    always_comb begin
        win_rd   = wb_act ? wb_rd_i : mdu_rd_i;
        win_data = wb_act ? wb_data_i : mdu_data_i;
        rf_wen_d = win ? ((32'd1 << win_rd) & 32'hFFFF_FFFE) : 32'd0;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rf_wen_q   <= '0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_wen_q <= rf_wen_d;
            if (win) begin
                rf_waddr_q <= win_rd;
                rf_wdata_q <= win_data;
            end
        end
    end

    assign rf_wen_o   = rf_wen_q;
    assign rf_waddr_o = rf_waddr_q;
    assign rf_wdata_o = rf_wdata_q;

`ifdef REGWR_ARB_STARVE_GUARD_EN
    typedef enum logic [1:0] {IDLE, MDU_WAIT, MDU_FORCE} state_e;
    state_e     state_q;
    logic [3:0] cnt_q, cnt_inc;
    logic       stall_q, blocked;

    assign blocked = mdu_valid_i & ~mdu_ready_o;
    assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;

    // The blocked cycle seen in IDLE counts as the first starved cycle.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            stall_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, MDU_WAIT: begin
                    if (blocked && cnt_inc == 4'(STARVE_LIMIT)) begin
                        state_q <= MDU_FORCE;
                        cnt_q   <= '0;
                        stall_q <= 1'b1;
                    end else if (blocked) begin
                        state_q <= MDU_WAIT;
                        cnt_q   <= cnt_inc;
                    end else begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    assign stall_wb_o = stall_q;
`else
    assign stall_wb_o = 1'b0;
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed vectors for regfile_wr_arbiter.
module tb_regfile_wr_arbiter;
`ifdef REGWR_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        wb_we, mdu_valid, mdu_ready, stall_wb;
    logic [4:0]  wb_rd, mdu_rd, rf_waddr;
    logic [31:0] wb_data, mdu_data, rf_wen, rf_wdata;
    int          n_chk = 0, n_pass = 0;

    regfile_wr_arbiter #(.DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clock_i(clk), .reset_n_i(rst_n),
        .wb_we_i(wb_we), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .mdu_valid_i(mdu_valid), .mdu_rd_i(mdu_rd), .mdu_data_i(mdu_data),
        .mdu_ready_o(mdu_ready), .stall_wb_o(stall_wb),
        .rf_wen_o(rf_wen), .rf_waddr_o(rf_waddr), .rf_wdata_o(rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic drive(input logic we, input logic [4:0] rd, input logic [31:0] d,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] md);
        wb_we = we; wb_rd = rd; wb_data = d;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom);
        step;
        drive(1'b1, 5'($urandom), $urandom, 1'b1, 5'($urandom), $urandom);
        step;
        check("rst_wen", rf_wen, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_stall", stall_wb, 0);
        drive(1'b0, 5'd0, 0, 1'b0, 5'd0, 0);
        rst_n = 1'b1;
        #1 check("rst_ready", mdu_ready, 1);
        // WB only
        step;
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 0);
        step;
        check("wb_wen", rf_wen, 32'h20);
        check("wb_waddr", rf_waddr, 5);
        check("wb_wdata", rf_wdata, 32'hDEADBEEF);
        // collision: WB first, MDU next cycle
        drive(1'b1, 5'd3, 32'hAAAA0003, 1'b1, 5'd7, 32'hBBBB0007);
        #1 check("col_ready0", mdu_ready, 0);
        step;
        check("col_wen_wb", rf_wen, 32'h08);
        drive(1'b0, 5'd0, 0, 1'b1, 5'd7, 32'hBBBB0007);
        #1 check("col_ready1", mdu_ready, 1);
        step;
        check("col_wen_mdu", rf_wen, 32'h80);
        check("col_wdata", rf_wdata, 32'hBBBB0007);
        drive(1'b0, 5'd0, 0, 1'b0, 5'd0, 0);
        step;
        check("idle_wen", rf_wen, 0);
        check("idle_hold", rf_waddr, 7);
        // r0 handling
        drive(1'b1, 5'd0, 32'h0BAD0000, 1'b1, 5'd9, 32'h1234);
        #1 check("r0_ready", mdu_ready, 1);
        step;
        check("r0_wen", rf_wen, 32'h200);
        check("r0_wdata", rf_wdata, 32'h1234);
        drive(1'b0, 5'd0, 0, 1'b1, 5'd0, 32'h5555);
        step;
        check("mdu_r0_wen", rf_wen, 0);
        check("mdu_r0_waddr", rf_waddr, 0);
        drive(1'b0, 5'd0, 0, 1'b0, 5'd0, 0);
        step;
        // starvation
        drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd4, 32'h4444);
        for (int i = 1; i <= 4; i++) begin
            step;
            check($sformatf("starve_stall%0d", i), stall_wb, (GUARD && i == 4) ? 1 : 0);
            check($sformatf("starve_wen%0d", i), rf_wen, 32'h04);
        end
        check("starve_ready", mdu_ready, GUARD ? 1 : 0);
        step;
        check("starve_wen_mdu", rf_wen, GUARD ? 32'h10 : 32'h04);
        check("starve_stall_fall", stall_wb, 0);
        drive(1'b0, 5'd0, 0, 1'b0, 5'd0, 0);
        step;
        // reset in the middle of a wait
        drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd4, 32'h4444);
        step; step; step;
        check("mid_wen_pre", rf_wen, 32'h04);
        #2 rst_n = 1'b0;
        #1;
        check("mid_wen", rf_wen, 0);
        check("mid_waddr", rf_waddr, 0);
        check("mid_wdata", rf_wdata, 0);
        check("mid_stall", stall_wb, 0);
        #1 rst_n = 1'b1;
        drive(1'b0, 5'd0, 0, 1'b1, 5'd4, 32'h4444);
        #1 check("mid_ready", mdu_ready, 1);
        step;
        check("mid_wen_mdu", rf_wen, 32'h10);
        check("mid_wdata_mdu", rf_wdata, 32'h4444);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
